// File: rtl/dispensador_rolhas_lote.sv
// Cork stock counter that serves REQ/ACK batch requests, releasing one cork per
// clock on ROLHA, with saturating refill, optional short batches and a running total.
module dispensador_rolhas_lote #(
    parameter int WIDTH        = 8,
    parameter int LOTE         = 15,
    parameter int LIMIAR_BAIXO = 20,
    parameter int PARCIAL      = 1,
    parameter int TOTAL_WIDTH  = 16
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   LOAD,
    input  logic                   ADD,
    input  logic [WIDTH-1:0]       DADOS,
    input  logic                   REQ,
    output logic                   ACK,
    output logic                   BUSY,
    output logic                   ROLHA,
    output logic [WIDTH-1:0]       ESTOQUE,
    output logic [WIDTH-1:0]       DISPENSADO,
    output logic [TOTAL_WIDTH-1:0] TOTAL,
    output logic                   VAZIO,
    output logic                   BAIXO,
    output logic                   ERRO
);

    localparam logic [WIDTH-1:0]       LOTE_W      = WIDTH'(LOTE);
    localparam logic [WIDTH-1:0]       ESTOQUE_MAX = '1;
    localparam logic [TOTAL_WIDTH-1:0] TOTAL_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSA,
        FIM
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] alvo;
    logic [WIDTH-1:0] cont;
    logic [WIDTH-1:0] alvo_pedido;
    logic [WIDTH:0]   soma;
    logic             req_aceito;
    logic             req_rejeitado;

    assign VAZIO = (ESTOQUE == '0);
    assign BAIXO = (int'(ESTOQUE) < LIMIAR_BAIXO);

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        req_aceito    = 1'b0;
        req_rejeitado = 1'b0;
        soma          = {1'b0, ESTOQUE} + {1'b0, DADOS};
        alvo_pedido   = (ESTOQUE < LOTE_W) ? ESTOQUE : LOTE_W;
        case (state)
            IDLE: begin
                // LOAD and ADD take precedence and silently swallow a coincident REQ.
                if (!LOAD && !ADD && REQ) begin
                    if (VAZIO || ((ESTOQUE < LOTE_W) && (PARCIAL == 0))) begin
                        req_rejeitado = 1'b1;
                    end else begin
                        req_aceito = 1'b1;
                        state_next = DISPENSA;
                    end
                end
            end
            DISPENSA: begin
                if (cont == alvo - WIDTH'(1)) begin
                    state_next = FIM;
                end
            end
            FIM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are registered from the next state so they line up exactly with the state they decode.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ACK        <= 1'b0;
            BUSY       <= 1'b0;
            ROLHA      <= 1'b0;
            ERRO       <= 1'b0;
            ESTOQUE    <= '0;
            DISPENSADO <= '0;
            TOTAL      <= '0;
            alvo       <= '0;
            cont       <= '0;
        end else begin
            ROLHA <= (state_next == DISPENSA);
            ACK   <= (state_next == FIM);
            BUSY  <= (state_next != IDLE);
            ERRO  <= req_rejeitado;
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        ESTOQUE <= DADOS;
                    end else if (ADD) begin
                        ESTOQUE <= soma[WIDTH] ? ESTOQUE_MAX : soma[WIDTH-1:0];
                    end
                    if (req_aceito) begin
                        alvo <= alvo_pedido;
                        cont <= '0;
                    end
                end
                DISPENSA: begin
                    // alvo never exceeds the stock at acceptance, so this cannot wrap.
                    ESTOQUE <= ESTOQUE - WIDTH'(1);
                    cont    <= cont + WIDTH'(1);
                    if (TOTAL != TOTAL_MAX) begin
                        TOTAL <= TOTAL + TOTAL_WIDTH'(1);
                    end
                end
                FIM: begin
                    DISPENSADO <= alvo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dispensador_rolhas_lote.sv
// Bench for dispensador_rolhas_lote: a PARCIAL=1 and a PARCIAL=0 instance share stimulus
// and are compared each cycle against a countdown-schedule reference model.
module tb_dispensador_rolhas_lote;

    localparam int WIDTH  = 8;
    localparam int LOTE   = 15;
    localparam int LIMIAR = 20;
    localparam int TW     = 16;

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             LOAD;
    logic             ADD;
    logic             REQ;
    logic [WIDTH-1:0] DADOS;

    logic             ack_p, busy_p, rolha_p, vazio_p, baixo_p, erro_p;
    logic [WIDTH-1:0] estoque_p, disp_p;
    logic [TW-1:0]    total_p;
    logic             ack_r, busy_r, rolha_r, vazio_r, baixo_r, erro_r;
    logic [WIDTH-1:0] estoque_r, disp_r;
    logic [TW-1:0]    total_r;

    int vectors;
    int miscompares;

    always #5 CLOCK = ~CLOCK;

    dispensador_rolhas_lote #(.WIDTH(WIDTH), .LOTE(LOTE), .LIMIAR_BAIXO(LIMIAR),
                              .PARCIAL(1), .TOTAL_WIDTH(TW)) dut_p (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .ADD(ADD), .DADOS(DADOS), .REQ(REQ),
        .ACK(ack_p), .BUSY(busy_p), .ROLHA(rolha_p), .ESTOQUE(estoque_p),
        .DISPENSADO(disp_p), .TOTAL(total_p), .VAZIO(vazio_p), .BAIXO(baixo_p), .ERRO(erro_p));

    dispensador_rolhas_lote #(.WIDTH(WIDTH), .LOTE(LOTE), .LIMIAR_BAIXO(LIMIAR),
                              .PARCIAL(0), .TOTAL_WIDTH(TW)) dut_r (
        .CLOCK(CLOCK), .RESET(RESET), .LOAD(LOAD), .ADD(ADD), .DADOS(DADOS), .REQ(REQ),
        .ACK(ack_r), .BUSY(busy_r), .ROLHA(rolha_r), .ESTOQUE(estoque_r),
        .DISPENSADO(disp_r), .TOTAL(total_r), .VAZIO(vazio_r), .BAIXO(baixo_r), .ERRO(erro_r));

    // sched = busy cycles still ahead including the current one: >1 releases a cork, ==1 is the ACK cycle.
    typedef struct {
        int stock;
        int total;
        int dispensado;
        int alvo;
        int sched;
        int erro;
    } mdl_t;

    mdl_t m_p;
    mdl_t m_r;

    typedef struct {
        logic       load;
        logic       add;
        logic       req;
        logic [7:0] dados;
        logic [7:0] estoque;
        logic       rolha;
        logic       ack;
        logic       erro;
        logic       busy;
    } vec_t;

    vec_t tab[22];

    function automatic mdl_t model_step(mdl_t m, bit parcial);
        mdl_t n = m;
        n.erro = 0;
        if (m.sched > 0) begin
            if (m.sched > 1) begin
                n.stock = m.stock - 1;
                if (m.total < (1 << TW) - 1) n.total = m.total + 1;
            end else begin
                n.dispensado = m.alvo;
            end
            n.sched = m.sched - 1;
        end else if (LOAD) begin
            n.stock = int'(DADOS);
        end else if (ADD) begin
            n.stock = (m.stock + int'(DADOS) > 255) ? 255 : m.stock + int'(DADOS);
        end else if (REQ) begin
            if (m.stock == 0 || (m.stock < LOTE && !parcial)) begin
                n.erro = 1;
            end else begin
                n.alvo  = (m.stock < LOTE) ? m.stock : LOTE;
                n.sched = n.alvo + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [37:0] model_pack(mdl_t m);
        return {m.sched == 1, m.sched > 0, m.sched > 1, m.erro != 0, m.stock == 0,
                m.stock < LIMIAR, 8'(m.stock), 8'(m.dispensado), 16'(m.total)};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_models();
        check("model_parcial",
              {ack_p, busy_p, rolha_p, erro_p, vazio_p, baixo_p, estoque_p, disp_p, total_p},
              model_pack(m_p));
        check("model_rejeita",
              {ack_r, busy_r, rolha_r, erro_r, vazio_r, baixo_r, estoque_r, disp_r, total_r},
              model_pack(m_r));
    endtask

    task automatic cycle();
        @(posedge CLOCK);
        m_p = model_step(m_p, 1'b1);
        m_r = model_step(m_r, 1'b0);
        #1;
        check_models();
    endtask

    task automatic idle_inputs();
        LOAD  = 1'b0;
        ADD   = 1'b0;
        REQ   = 1'b0;
        DADOS = '0;
    endtask

    task automatic models_reset();
        m_p = '{default: 0};
        m_r = '{default: 0};
    endtask

    task automatic full_reset();
        #2 RESET = 1'b0;
        models_reset();
        #1 check_models();
        #2 RESET = 1'b1;
    endtask

    initial begin
        int rolhas_p;
        int rolhas_r;
        int erro_visto;
        int acks;
        int ack_cycle;
        int start2;

        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        idle_inputs();
        models_reset();

        tab[0]  = '{1'b1, 1'b0, 1'b0, 8'd40,  8'd40,  1'b0, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd40,  1'b1, 1'b0, 1'b0, 1'b1};
        for (int r = 2; r <= 15; r++) begin
            tab[r] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'(41 - r), 1'b1, 1'b0, 1'b0, 1'b1};
        end
        tab[16] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd25,  1'b0, 1'b1, 1'b0, 1'b1};
        tab[17] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd25,  1'b0, 1'b0, 1'b0, 1'b0};
        tab[18] = '{1'b1, 1'b0, 1'b0, 8'd250, 8'd250, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[19] = '{1'b0, 1'b1, 1'b0, 8'd10,  8'd255, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[20] = '{1'b1, 1'b0, 1'b1, 8'd5,   8'd5,   1'b0, 1'b0, 1'b0, 1'b0};
        tab[21] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd5,   1'b0, 1'b0, 1'b0, 1'b0};

        #3 check_models();
        check("reset_vazio_baixo", {vazio_p, baixo_p, busy_p}, 3'b110);
        #9 RESET = 1'b1;

        // Full batch, refill saturation and LOAD-over-REQ priority.
        for (int i = 0; i < 22; i++) begin
            LOAD  = tab[i].load;
            ADD   = tab[i].add;
            REQ   = tab[i].req;
            DADOS = tab[i].dados;
            cycle();
            check($sformatf("tab_%0d", i), {estoque_p, rolha_p, ack_p, erro_p, busy_p},
                  {tab[i].estoque, tab[i].rolha, tab[i].ack, tab[i].erro, tab[i].busy});
            if (i == 17) begin
                check("full_dispensado", disp_p, 15);
                check("full_total", total_p, 15);
                check("full_baixo", baixo_p, 0);
            end
        end
        idle_inputs();

        // Short batch: PARCIAL=1 serves 7 corks, PARCIAL=0 rejects.
        LOAD = 1'b1; DADOS = 8'd7;
        cycle();
        idle_inputs(); REQ = 1'b1;
        rolhas_p = 0; rolhas_r = 0; erro_visto = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            REQ = 1'b0;
            rolhas_p += int'(rolha_p);
            rolhas_r += int'(rolha_r);
            erro_visto += int'(erro_r);
        end
        check("parcial_rolhas", rolhas_p, 7);
        check("parcial_estoque", {estoque_p, vazio_p, baixo_p}, {8'd0, 1'b1, 1'b1});
        check("parcial_dispensado", disp_p, 7);
        check("rejeita_rolhas", rolhas_r, 0);
        check("rejeita_erro", erro_visto, 1);
        check("rejeita_estoque", estoque_r, 7);

        REQ = 1'b1;
        cycle();
        REQ = 1'b0;
        check("vazio_erro", erro_p, 1);
        cycle();

        // Busy lockout and back-to-back batches with REQ held high.
        full_reset();
        LOAD = 1'b1; DADOS = 8'd40;
        cycle();
        idle_inputs(); REQ = 1'b1;
        acks = 0; ack_cycle = -100; start2 = -1;
        for (int c = 0; c < 60 && acks < 2; c++) begin
            LOAD  = (c == 2);
            DADOS = (c == 2) ? 8'd99 : 8'd0;
            cycle();
            if (ack_p) begin
                acks++;
                if (acks == 1) ack_cycle = c;
            end
            if (rolha_p && acks == 1 && start2 < 0) begin
                start2 = c;
                REQ    = 1'b0;
            end
        end
        idle_inputs();
        check("lockout_acks", acks, 2);
        check("lockout_gap", start2 - ack_cycle, 2);
        check("lockout_estoque", estoque_p, 10);
        check("lockout_total", total_p, 30);
        cycle();
        check("lockout_dispensado", disp_p, 15);

        // Asynchronous reset in the middle of a batch.
        LOAD = 1'b1; DADOS = 8'd40;
        cycle();
        idle_inputs(); REQ = 1'b1;
        cycle();
        REQ = 1'b0;
        cycle();
        cycle();
        full_reset();
        check("reset_meio", {ack_p, busy_p, rolha_p, estoque_p, total_p}, '0);
        cycle();
        REQ = 1'b1;
        cycle();
        REQ = 1'b0;
        check("reset_erro", {erro_p, erro_r}, 2'b11);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            LOAD  = ($urandom_range(0, 9) == 0);
            ADD   = ($urandom_range(0, 7) == 0);
            REQ   = ($urandom_range(0, 2) == 0);
            DADOS = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
            cycle();
        end
        idle_inputs();
        for (int c = 0; c < 20; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dispensador_rolhas_lote.md
Name: dispensador_rolhas_lote

Overview:
Parametrised successor of the bottling-line cork dispenser. It holds a cork stock counter and serves batch requests through a REQ/ACK handshake, releasing one cork per clock (ROLHA strobe) instead of subtracting a whole batch in one step. It adds saturating refill, optional partial batches, a low-stock alarm and a cumulative dispensed total. It sits between the line controller (REQ/ACK) and the cork feeder actuator (ROLHA).

Parameters:
WIDTH, 8, width of stock, data and per-batch count.
LOTE, 15, corks per full batch; legal range 1..2^WIDTH-1.
LIMIAR_BAIXO, 20, BAIXO asserts when ESTOQUE < LIMIAR_BAIXO.
PARCIAL, 1, 1 = serve a short batch when stock < LOTE; 0 = reject it.
TOTAL_WIDTH, 16, width of the cumulative dispensed counter.

Ports:
CLOCK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
LOAD  in  1  replace stock with DADOS.
ADD  in  1  add DADOS to stock, saturating.
DADOS  in  WIDTH  load/refill value.
REQ  in  1  batch request, level-sampled in IDLE.
ACK  out  1  one-cycle pulse: batch finished.
BUSY  out  1  high in DISPENSA and FIM.
ROLHA  out  1  one-cycle strobe per cork released.
ESTOQUE  out  WIDTH  current stock.
DISPENSADO  out  WIDTH  corks in last completed batch, held.
TOTAL  out  TOTAL_WIDTH  cumulative corks dispensed, saturating.
VAZIO  out  1  ESTOQUE == 0, combinational from register.
BAIXO  out  1  ESTOQUE < LIMIAR_BAIXO, combinational from register.
ERRO  out  1  one-cycle pulse: request rejected.

Behaviour:
- Reset (RESET=0, async): state IDLE. ESTOQUE, DISPENSADO, TOTAL and internal counters = 0. ACK, ROLHA, ERRO = 0. BUSY = 0, VAZIO = 1, BAIXO = 1 (if LIMIAR_BAIXO > 0). Reset mid-batch aborts with no ACK; corks already strobed stay deducted only if reset is not asserted (everything clears).
- FSM states: IDLE, DISPENSA, FIM.
- IDLE priority in the same cycle: LOAD > ADD > REQ.
  - LOAD: ESTOQUE <= DADOS.
  - ADD: ESTOQUE <= min(ESTOQUE + DADOS, 2^WIDTH-1).
  - When LOAD or ADD is taken, REQ is ignored that cycle with no ERRO.
- IDLE with REQ=1 and no LOAD/ADD:
  - VAZIO=1, or (ESTOQUE < LOTE and PARCIAL=0): ERRO=1 for the next cycle, stay in IDLE, stock unchanged.
  - Otherwise: alvo <= min(LOTE, ESTOQUE), cont <= 0, go to DISPENSA.
- DISPENSA, every cycle:
  - ROLHA=1, ESTOQUE <= ESTOQUE-1, cont <= cont+1, TOTAL <= min(TOTAL+1, 2^TOTAL_WIDTH-1).
  - When cont == alvo-1 (last cork), go to FIM.
- FIM, one cycle: ACK=1, DISPENSADO <= alvo, go to IDLE.
- Latency: REQ sampled at edge k. ROLHA is high for cycles k+1..k+N, where N = alvo. ACK is high in cycle k+N+1. BUSY is high over cycles k+1..k+N+1.
- REQ held high: it is re-evaluated in IDLE after ACK, giving one idle cycle between batches.
- LOAD, ADD and REQ are ignored (no ERRO) in DISPENSA and FIM.
- ESTOQUE never underflows: alvo ≤ ESTOQUE at acceptance, and the stock cannot change during a batch.
- Registered outputs: ACK, ROLHA, ERRO, BUSY are decoded from state and registered, so they are glitch-free.

Test Plan:
- Full batch: LOAD 40, then REQ for 1 cycle. Expect 15 consecutive ROLHA pulses, then ACK in cycle 16 after the sample edge. Then ESTOQUE=25, DISPENSADO=15, TOTAL=15, BAIXO=0.
- Partial batch (PARCIAL=1): LOAD 7, REQ. Expect 7 ROLHA pulses, then ACK. Then ESTOQUE=0, VAZIO=1, DISPENSADO=7, BAIXO=1.
- Rejections: with PARCIAL=0, stock 7, REQ → ERRO pulse, no ROLHA, ESTOQUE=7. With stock 0 (any PARCIAL), REQ → ERRO pulse.
- Refill and priority: LOAD 250, then ADD 10 → ESTOQUE=255. LOAD 5 with REQ in the same cycle → ESTOQUE=5, no batch, no ERRO.
- Busy lockout: LOAD 40, REQ, then LOAD 99 in the 3rd DISPENSA cycle → LOAD ignored, final ESTOQUE=25. REQ held high → second batch starts one cycle after ACK, ending at ESTOQUE=10, TOTAL=30.
- Async reset: assert RESET=0 mid-DISPENSA, between clock edges → all outputs go to reset values immediately, no ACK. After release, REQ → ERRO (stock 0).
